// File: rtl/branch_resolver.sv
// Resolves in-flight branch predictions in fetch order against actual outcomes.
// Drives predictor update strobes and keeps saturating branch/miss statistics.
module branch_resolver #(
  parameter int DEPTH = 4,
  parameter int PW    = 2,
  parameter int CW    = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          fetch_branch,
  input  logic          prediction,
  input  logic          resolve_valid,
  input  logic          resolve_taken,
  output logic          upd_branch,
  output logic          upd_taken,
  output logic          mispredict,
  output logic [PW:0]   pending_count,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] branch_count,
  output logic [CW-1:0] miss_count,
  output logic          overflow,
  output logic          underflow
);

  localparam logic [PW:0]   DepthC = (PW+1)'(DEPTH);
  localparam logic [CW-1:0] SatC   = '1;

  logic [DEPTH-1:0] mem_q, mem_d;
  logic [PW-1:0]    wp_q, wp_d, rp_q, rp_d;
  logic [PW:0]      cnt_q, cnt_d;
  logic             upd_branch_q, upd_branch_d;
  logic             upd_taken_q, upd_taken_d;
  logic             mispredict_q, mispredict_d;
  logic [CW-1:0]    branch_q, branch_d, miss_q, miss_d;
  logic             overflow_q, overflow_d, underflow_q, underflow_d;
  logic             push_ok, pop_ok, miss_now;

  assign full          = (cnt_q == DepthC);
  assign empty         = (cnt_q == '0);
  assign pending_count = cnt_q;

  // A pop frees a slot in the same cycle, so a push into a full queue is legal then.
  always_comb begin
    pop_ok       = resolve_valid && !empty;
    push_ok      = fetch_branch && (!full || pop_ok);
    miss_now     = pop_ok && (mem_q[rp_q] != resolve_taken);
    mem_d        = mem_q;
    wp_d         = wp_q;
    rp_d         = rp_q;
    cnt_d        = cnt_q;
    branch_d     = branch_q;
    miss_d       = miss_q;
    overflow_d   = overflow_q | (fetch_branch && !push_ok);
    underflow_d  = underflow_q | (resolve_valid && empty);
    upd_branch_d = pop_ok;
    upd_taken_d  = pop_ok && resolve_taken;
    mispredict_d = miss_now;
    if (push_ok) begin
      mem_d[wp_q] = prediction;
      wp_d        = wp_q + PW'(1);
    end
    if (pop_ok) begin
      rp_d = rp_q + PW'(1);
      if (branch_q != SatC) branch_d = branch_q + CW'(1);
    end
    if (miss_now && miss_q != SatC) miss_d = miss_q + CW'(1);
    case ({push_ok, pop_ok})
      2'b10:   cnt_d = cnt_q + (PW+1)'(1);
      2'b01:   cnt_d = cnt_q - (PW+1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_q        <= '0;
      wp_q         <= '0;
      rp_q         <= '0;
      cnt_q        <= '0;
      upd_branch_q <= 1'b0;
      upd_taken_q  <= 1'b0;
      mispredict_q <= 1'b0;
      branch_q     <= '0;
      miss_q       <= '0;
      overflow_q   <= 1'b0;
      underflow_q  <= 1'b0;
    end else begin
      mem_q        <= mem_d;
      wp_q         <= wp_d;
      rp_q         <= rp_d;
      cnt_q        <= cnt_d;
      upd_branch_q <= upd_branch_d;
      upd_taken_q  <= upd_taken_d;
      mispredict_q <= mispredict_d;
      branch_q     <= branch_d;
      miss_q       <= miss_d;
      overflow_q   <= overflow_d;
      underflow_q  <= underflow_d;
    end
  end

  assign upd_branch   = upd_branch_q;
  assign upd_taken    = upd_taken_q;
  assign mispredict   = mispredict_q;
  assign branch_count = branch_q;
  assign miss_count   = miss_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

endmodule

// File: tb/tb_branch_resolver.sv
// Directed bench for branch_resolver: FIFO matching, full/empty edges,
// sticky error flags, async reset, pointer wrap and counter saturation.
module tb_branch_resolver;

  logic       clk = 1'b0;
  logic       reset;
  logic       fetchBranch, prediction, resolveValid, resolveTaken;
  logic       updBranch, updTaken, mispredict, full, empty, overflow, underflow;
  logic [2:0] pendingCount;
  logic [7:0] branchCount, missCount;
  logic       satUpdBranch, satUpdTaken, satMispredict, satFull, satEmpty;
  logic       satOverflow, satUnderflow;
  logic [2:0] satPending, satBranch, satMiss;
  int         passed = 0;
  int         total  = 0;

  always #5 clk = ~clk;

  branch_resolver dut (
    .clk(clk), .reset(reset), .fetch_branch(fetchBranch), .prediction(prediction),
    .resolve_valid(resolveValid), .resolve_taken(resolveTaken),
    .upd_branch(updBranch), .upd_taken(updTaken), .mispredict(mispredict),
    .pending_count(pendingCount), .full(full), .empty(empty),
    .branch_count(branchCount), .miss_count(missCount),
    .overflow(overflow), .underflow(underflow)
  );

  // Narrow-counter instance that shares all stimulus, used for saturation.
  branch_resolver #(.DEPTH(4), .PW(2), .CW(3)) dutSat (
    .clk(clk), .reset(reset), .fetch_branch(fetchBranch), .prediction(prediction),
    .resolve_valid(resolveValid), .resolve_taken(resolveTaken),
    .upd_branch(satUpdBranch), .upd_taken(satUpdTaken), .mispredict(satMispredict),
    .pending_count(satPending), .full(satFull), .empty(satEmpty),
    .branch_count(satBranch), .miss_count(satMiss),
    .overflow(satOverflow), .underflow(satUnderflow)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs === exp) passed++;
    else $display("[TB] FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  // Drive one cycle of inputs, then settle just after the edge so outputs reflect it.
  task automatic applyStimulus(input logic fb, input logic pred, input logic rv, input logic rt);
    fetchBranch  = fb;
    prediction   = pred;
    resolveValid = rv;
    resolveTaken = rt;
    @(posedge clk);
    #1;
    fetchBranch  = 1'b0;
    prediction   = 1'b0;
    resolveValid = 1'b0;
    resolveTaken = 1'b0;
  endtask

  task automatic doReset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    fetchBranch = 0; prediction = 0; resolveValid = 0; resolveTaken = 0;
    doReset();
    checkOutput("rst_upd_branch", updBranch, 0);
    checkOutput("rst_upd_taken", updTaken, 0);
    checkOutput("rst_mispredict", mispredict, 0);
    checkOutput("rst_pending", pendingCount, 0);
    checkOutput("rst_empty", empty, 1);
    checkOutput("rst_full", full, 0);
    checkOutput("rst_branch", branchCount, 0);
    checkOutput("rst_miss", missCount, 0);
    checkOutput("rst_overflow", overflow, 0);
    checkOutput("rst_underflow", underflow, 0);

    // Predictions 1,0,1 resolved as 1,1,0.
    applyStimulus(1, 1, 0, 0);
    checkOutput("push_no_upd", updBranch, 0);
    applyStimulus(1, 0, 0, 0);
    applyStimulus(1, 1, 0, 0);
    checkOutput("pend3", pendingCount, 3);
    applyStimulus(0, 0, 1, 1);
    checkOutput("r1_upd", updBranch, 1);
    checkOutput("r1_taken", updTaken, 1);
    checkOutput("r1_miss", mispredict, 0);
    applyStimulus(0, 0, 1, 1);
    checkOutput("r2_upd", updBranch, 1);
    checkOutput("r2_taken", updTaken, 1);
    checkOutput("r2_miss", mispredict, 1);
    applyStimulus(0, 0, 1, 0);
    checkOutput("r3_upd", updBranch, 1);
    checkOutput("r3_taken", updTaken, 0);
    checkOutput("r3_miss", mispredict, 1);
    applyStimulus(0, 0, 0, 0);
    checkOutput("idle_upd", updBranch, 0);
    checkOutput("idle_miss", mispredict, 0);
    checkOutput("seq_branch", branchCount, 3);
    checkOutput("seq_miss", missCount, 2);
    checkOutput("seq_empty", empty, 1);

    // Fill with 1,1,0,0, overflow, then push+pop while full.
    applyStimulus(1, 1, 0, 0);
    applyStimulus(1, 1, 0, 0);
    applyStimulus(1, 0, 0, 0);
    checkOutput("fill3_full", full, 0);
    applyStimulus(1, 0, 0, 0);
    checkOutput("fill_full", full, 1);
    checkOutput("fill_pend", pendingCount, 4);
    checkOutput("fill_ovf_clear", overflow, 0);
    applyStimulus(1, 1, 0, 0);
    checkOutput("ovf_set", overflow, 1);
    checkOutput("ovf_pend", pendingCount, 4);
    applyStimulus(1, 1, 1, 1);
    checkOutput("pp_upd", updBranch, 1);
    checkOutput("pp_miss", mispredict, 0);
    checkOutput("pp_pend", pendingCount, 4);
    checkOutput("pp_full", full, 1);
    checkOutput("pp_ovf", overflow, 1);
    // Remaining queue is 1,0,0,1; the dropped push must not appear.
    applyStimulus(0, 0, 1, 1);
    checkOutput("d1_miss", mispredict, 0);
    applyStimulus(0, 0, 1, 1);
    checkOutput("d2_miss", mispredict, 1);
    applyStimulus(0, 0, 1, 1);
    checkOutput("d3_miss", mispredict, 1);
    applyStimulus(0, 0, 1, 1);
    checkOutput("d4_miss", mispredict, 0);
    checkOutput("drain_empty", empty, 1);
    checkOutput("drain_branch", branchCount, 8);
    checkOutput("drain_miss", missCount, 4);

    // Resolve while empty, also with a simultaneous push (no bypass).
    applyStimulus(0, 0, 1, 1);
    checkOutput("unf_set", underflow, 1);
    checkOutput("unf_upd", updBranch, 0);
    checkOutput("unf_branch", branchCount, 8);
    applyStimulus(1, 0, 1, 1);
    checkOutput("unf_push_upd", updBranch, 0);
    checkOutput("unf_push_pend", pendingCount, 1);
    checkOutput("unf_push_branch", branchCount, 8);

    // Async reset with 3 pending must clear immediately and emit no strobe.
    applyStimulus(1, 1, 0, 0);
    applyStimulus(1, 0, 0, 0);
    checkOutput("pre_rst_pend", pendingCount, 3);
    #2 reset = 1'b1;
    #1;
    checkOutput("async_pend", pendingCount, 0);
    checkOutput("async_empty", empty, 1);
    checkOutput("async_ovf", overflow, 0);
    checkOutput("async_unf", underflow, 0);
    checkOutput("async_branch", branchCount, 0);
    @(posedge clk);
    #2 reset = 1'b0;
    applyStimulus(0, 0, 0, 0);
    checkOutput("post_rst_upd", updBranch, 0);
    checkOutput("post_rst_pend", pendingCount, 0);

    // Ten push/resolve pairs with alternating predictions force pointer wrap.
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1, (i % 2 == 0) ? 1'b1 : 1'b0, 0, 0);
      applyStimulus(0, 0, 1, 1);
      checkOutput($sformatf("wrap%0d_miss", i), mispredict, (i % 2 == 0) ? 0 : 1);
    end
    checkOutput("wrap_miss_cnt", missCount, 5);
    checkOutput("wrap_branch_cnt", branchCount, 10);
    checkOutput("wrap_empty", empty, 1);

    // Saturation on the 3-bit instance: nine mispredicted resolves.
    doReset();
    applyStimulus(1, 0, 0, 0);
    for (int i = 0; i < 9; i++) begin
      applyStimulus(1, 0, 1, 1);
      if (i == 6) begin
        checkOutput("sat7_branch", satBranch, 7);
        checkOutput("sat7_miss", satMiss, 7);
      end
    end
    checkOutput("sat_branch", satBranch, 7);
    checkOutput("sat_miss", satMiss, 7);
    checkOutput("sat_last_miss", satMispredict, 1);
    checkOutput("sat_pend", satPending, 1);
    checkOutput("wide_branch", branchCount, 9);
    checkOutput("wide_miss", missCount, 9);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
